// File: rtl/grant_decoder_if.sv
// grant_decoder_if: request/release inputs and registered grant outputs of the grant decoder.
interface grant_decoder_if #(
    parameter int WIDTH = 64
);
    localparam int IDX_W = WIDTH > 2 ? $clog2(WIDTH) : 1;
    logic [IDX_W-1:0] encode;
    logic             valid;
    logic [WIDTH-1:0] done;
    logic             flush;
    logic [WIDTH-1:0] grant;
    logic [IDX_W-1:0] owner;
    logic             accept;
    logic             busy;
    logic             err;
    modport master (
        output encode, valid, done, flush,
        input  grant, owner, accept, busy, err
    );
    modport slave (
        input  encode, valid, done, flush,
        output grant, owner, accept, busy, err
    );
endinterface

// File: rtl/grant_decoder.sv
// grant_decoder: expands a winning index into a held one-hot grant with timeout and a dead cycle.
module grant_decoder #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 0
) (
    input logic            clk,
    input logic            rst_n,
    grant_decoder_if.slave bus
);
    localparam int IDX_W = WIDTH > 2 ? $clog2(WIDTH) : 1;
    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W:0]   LIMIT   = (IDX_W + 1)'(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] grant_n;
    logic [IDX_W-1:0] owner_n;
    logic             accept_n, busy_n, err_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             in_range, released, timed_out;

    always_comb begin
        in_range  = {1'b0, bus.encode} < LIMIT;
        released  = bus.done[bus.owner] | bus.flush;
        timed_out = TIMEOUT > 0 && cnt == LAST;
        state_n   = state;
        grant_n   = bus.grant;
        owner_n   = bus.owner;
        accept_n  = 1'b0;
        busy_n    = bus.busy;
        err_n     = 1'b0;
        cnt_n     = cnt;
        case (state)
            IDLE: begin
                if (!bus.flush && bus.valid) begin
                    if (in_range) begin
                        grant_n  = {{(WIDTH-1){1'b0}}, 1'b1} << bus.encode;
                        owner_n  = bus.encode;
                        accept_n = 1'b1;
                        busy_n   = 1'b1;
                        cnt_n    = '0;
                        state_n  = GRANT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            GRANT: begin
                // an explicit release on the last allowed cycle beats the timeout
                if (released) begin
                    grant_n = '0;
                    state_n = HOLDOFF;
                end else if (timed_out) begin
                    grant_n = '0;
                    err_n   = 1'b1;
                    state_n = HOLDOFF;
                end else if (TIMEOUT > 0 && cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLDOFF: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.grant  <= '0;
            bus.owner  <= '0;
            bus.accept <= 1'b0;
            bus.busy   <= 1'b0;
            bus.err    <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            bus.grant  <= grant_n;
            bus.owner  <= owner_n;
            bus.accept <= accept_n;
            bus.busy   <= busy_n;
            bus.err    <= err_n;
            cnt        <= cnt_n;
        end
    end
endmodule

// File: tb/tb_grant_decoder.sv
// tb_grant_decoder: three configurations driven in lockstep and checked against a cycle-count model.
module tb_grant_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] enc = '0;
    logic       val = 1'b0;
    logic [7:0] dn = '0;
    logic       fl = 1'b0;
    int checks = 0;
    int errors = 0;

    grant_decoder_if #(.WIDTH(8)) bus8 ();
    grant_decoder_if #(.WIDTH(6)) bus6 ();
    grant_decoder_if #(.WIDTH(8)) bust ();

    assign bus8.encode = enc;
    assign bus8.valid  = val;
    assign bus8.done   = dn;
    assign bus8.flush  = fl;
    assign bus6.encode = enc;
    assign bus6.valid  = val;
    assign bus6.done   = dn[5:0];
    assign bus6.flush  = fl;
    assign bust.encode = enc;
    assign bust.valid  = val;
    assign bust.done   = dn;
    assign bust.flush  = fl;

    grant_decoder #(.WIDTH(8), .TIMEOUT(0)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    grant_decoder #(.WIDTH(6), .TIMEOUT(3)) u6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
    grant_decoder #(.WIDTH(8), .TIMEOUT(4)) ut (.clk(clk), .rst_n(rst_n), .bus(bust));

    // held = cycles the grant has been up so far (0 = none); gap = dead cycle pending
    typedef struct {
        int held;
        int gap;
        int own;
        bit acc;
        bit er;
    } model_t;

    model_t m8 = '{0, 0, 0, 1'b0, 1'b0};
    model_t m6 = '{0, 0, 0, 1'b0, 1'b0};
    model_t mt = '{0, 0, 0, 1'b0, 1'b0};

    function automatic model_t step(model_t m, int w, int to, int e, bit v, logic [7:0] d, bit f);
        model_t n = m;
        n.acc = 1'b0;
        n.er  = 1'b0;
        if (m.held > 0) begin
            if (d[m.own] || f) begin
                n.held = 0;
                n.gap  = 1;
            end else if (to > 0 && m.held == to) begin
                n.held = 0;
                n.gap  = 1;
                n.er   = 1'b1;
            end else begin
                n.held = m.held + 1;
            end
        end else if (m.gap > 0) begin
            n.gap = 0;
        end else if (!f && v) begin
            if (e < w) begin
                n.held = 1;
                n.own  = e;
                n.acc  = 1'b1;
            end else begin
                n.er = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8 <= '{0, 0, 0, 1'b0, 1'b0};
            m6 <= '{0, 0, 0, 1'b0, 1'b0};
            mt <= '{0, 0, 0, 1'b0, 1'b0};
        end else begin
            m8 <= step(m8, 8, 0, int'(enc), val, dn, fl);
            m6 <= step(m6, 6, 3, int'(enc), val, {2'b00, dn[5:0]}, fl);
            mt <= step(mt, 8, 4, int'(enc), val, dn, fl);
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic cmp(string t, model_t m, logic [7:0] g, logic [2:0] o, logic a, logic b, logic e);
        logic [7:0] eg;
        eg = m.held > 0 ? 8'(1 << m.own) : 8'h00;
        chk({t, ".grant"}, 32'(g), 32'(eg));
        chk({t, ".owner"}, 32'(o), 32'(m.own));
        chk({t, ".accept"}, 32'(a), 32'(m.acc));
        chk({t, ".busy"}, 32'(b), 32'(m.held > 0 || m.gap > 0));
        chk({t, ".err"}, 32'(e), 32'(m.er));
        chk({t, ".onehot0"}, 32'($onehot0(g)), 32'd1);
        if (g != 8'h00) chk({t, ".grant_owner_bit"}, 32'(g[o]), 32'd1);
        if (a) chk({t, ".accept_has_grant"}, 32'(g != 8'h00), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("w8", m8, bus8.grant, bus8.owner, bus8.accept, bus8.busy, bus8.err);
            cmp("w6", m6, {2'b00, bus6.grant}, bus6.owner, bus6.accept, bus6.busy, bus6.err);
            cmp("t4", mt, bust.grant, bust.owner, bust.accept, bust.busy, bust.err);
        end
    end

    task automatic go(int e, bit v, logic [7:0] d, bit f);
        enc = 3'(e);
        val = v;
        dn  = d;
        fl  = f;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.grant", 32'(bus8.grant), 0);
        chk("rst.owner", 32'(bus8.owner), 0);
        chk("rst.accept", 32'(bus8.accept), 0);
        chk("rst.busy", 32'(bus8.busy), 0);
        chk("rst.err", 32'(bust.err), 0);
        rst_n = 1'b1;
        go(0, 0, 8'h00, 0);

        go(5, 1, 8'h00, 0);
        chk("basic.grant", 32'(bus8.grant), 32'h20);
        chk("basic.accept", 32'(bus8.accept), 1);
        chk("basic.busy", 32'(bus8.busy), 1);
        go(0, 0, 8'h00, 0);
        chk("basic.accept_fall", 32'(bus8.accept), 0);
        chk("basic.grant_held", 32'(bus8.grant), 32'h20);
        go(0, 0, 8'h20, 0);
        chk("basic.release", 32'(bus8.grant), 0);
        chk("basic.holdoff_busy", 32'(bus8.busy), 1);
        go(0, 0, 8'h00, 0);
        chk("basic.idle_busy", 32'(bus8.busy), 0);

        go(2, 1, 8'h00, 0);
        chk("foreign.grant", 32'(bus8.grant), 32'h04);
        go(0, 0, 8'hFB, 0);
        chk("foreign.ignored", 32'(bus8.grant), 32'h04);
        go(0, 0, 8'h04, 0);
        chk("foreign.release", 32'(bus8.grant), 0);
        go(0, 0, 8'h00, 0);

        go(3, 1, 8'h08, 0);
        chk("b2b.grant1", 32'(bus8.grant), 32'h08);
        chk("b2b.accept1", 32'(bus8.accept), 1);
        go(3, 1, 8'h08, 0);
        chk("b2b.holdoff", 32'(bus8.grant), 0);
        chk("b2b.holdoff_accept", 32'(bus8.accept), 0);
        go(3, 1, 8'h08, 0);
        chk("b2b.idle", 32'(bus8.grant), 0);
        go(3, 1, 8'h00, 0);
        chk("b2b.grant2", 32'(bus8.grant), 32'h08);
        chk("b2b.accept2", 32'(bus8.accept), 1);
        go(0, 0, 8'h08, 0);
        go(0, 0, 8'h00, 0);

        go(7, 1, 8'h00, 0);
        chk("invalid.err", 32'(bus6.err), 1);
        chk("invalid.grant", 32'(bus6.grant), 0);
        chk("invalid.busy", 32'(bus6.busy), 0);
        go(5, 1, 8'h00, 0);
        chk("invalid.next_grant", 32'(bus6.grant), 32'h20);
        chk("invalid.err_fall", 32'(bus6.err), 0);
        go(0, 0, 8'hA0, 0);
        go(0, 0, 8'h00, 0);
        go(0, 0, 8'h00, 0);

        go(1, 1, 8'h00, 0);
        chk("timeout.grant1", 32'(bust.grant), 32'h02);
        go(0, 0, 8'h00, 0);
        go(0, 0, 8'h00, 0);
        go(0, 0, 8'h00, 0);
        chk("timeout.grant4", 32'(bust.grant), 32'h02);
        chk("timeout.no_err_yet", 32'(bust.err), 0);
        go(0, 0, 8'h00, 0);
        chk("timeout.drop", 32'(bust.grant), 0);
        chk("timeout.err", 32'(bust.err), 1);
        chk("timeout.holdoff_busy", 32'(bust.busy), 1);
        go(0, 0, 8'h00, 0);
        chk("timeout.err_fall", 32'(bust.err), 0);
        chk("timeout.idle_busy", 32'(bust.busy), 0);
        go(0, 0, 8'h02, 0);
        go(0, 0, 8'h00, 0);

        go(1, 1, 8'h00, 0);
        go(0, 0, 8'h00, 0);
        go(0, 0, 8'h00, 0);
        go(0, 0, 8'h00, 0);
        go(0, 0, 8'h02, 0);
        chk("late_release.grant", 32'(bust.grant), 0);
        chk("late_release.err", 32'(bust.err), 0);
        go(0, 0, 8'h00, 0);

        go(4, 1, 8'h00, 0);
        chk("flush.grant", 32'(bus8.grant), 32'h10);
        go(0, 0, 8'h00, 1);
        chk("flush.release", 32'(bus8.grant), 0);
        chk("flush.err", 32'(bus8.err), 0);
        go(0, 0, 8'h00, 0);
        go(4, 1, 8'h00, 1);
        chk("flush_idle.grant", 32'(bus8.grant), 0);
        chk("flush_idle.accept", 32'(bus8.accept), 0);
        go(0, 0, 8'h00, 0);

        go(6, 1, 8'h00, 0);
        chk("areset.pre_grant", 32'(bus8.grant), 32'h40);
        val = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("areset.grant", 32'(bus8.grant), 0);
        chk("areset.busy", 32'(bus8.busy), 0);
        chk("areset.owner", 32'(bus8.owner), 0);
        chk("areset.t_grant", 32'(bust.grant), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        repeat (3000)
            go(int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
               $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00, $urandom_range(0, 15) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
